pwm_meas: RTL and testbench
===========================

PWM_MEAS -- requirements
Module: pwm_meas

Interface
REQ-001 SHALL have parameter WIDTH, default 8, setting the bit width of the counters and measurement outputs.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port ena, input, 1 bit: block enable; low forces IDLE.
REQ-005 SHALL have port pwm_in, input, 1 bit: asynchronous PWM input.
REQ-006 SHALL have port duty_out, output, WIDTH bits: high-time of the last complete period, in clk cycles.
REQ-007 SHALL have port period_out, output, WIDTH bits: length of the last complete period, in clk cycles.
REQ-008 SHALL have port valid, output, 1 bit: one-cycle pulse when duty_out and period_out update.
REQ-009 SHALL have port timeout, output, 1 bit: level; high while the last update was caused by saturation.

Function
REQ-010 SHALL synchronise pwm_in through 2 flops; the second flop is the sampled level lvl.
REQ-011 SHALL register lvl as lvl_q and detect rise = lvl & ~lvl_q.
REQ-012 SHALL implement FSM IDLE -> MEASURE on rise, and MEASURE -> IDLE on saturation or on ena low.
REQ-013 SHALL produce no valid pulse on the first rise after IDLE; that rise only arms the measurement.
REQ-014 On a rise, SHALL load the period counter pcnt with 1 and the high counter hcnt with 1.
REQ-015 In MEASURE with no rise, SHALL increment pcnt every cycle and increment hcnt only while lvl=1.
REQ-016 On a rise in MEASURE, SHALL register period_out<=pcnt and duty_out<=hcnt, pulse valid, and clear timeout, all in the same edge.
REQ-017 SHALL give a square wave with P-cycle period and H high cycles period_out=P and duty_out=H; 0<H<P is required.
REQ-018 If pcnt reaches 2^WIDTH-1 in MEASURE with no rise, SHALL load period_out=all-ones and duty_out=(lvl ? all-ones : 0), pulse valid, set timeout, and go to IDLE.
REQ-019 A rise coincident with saturation SHALL take precedence as a normal measurement (REQ-016).
REQ-020 While ena=0, SHALL hold state IDLE with counters at 0, hold duty_out, period_out and timeout, and keep valid=0.
REQ-021 Latency from a pwm_in rising edge to the valid pulse SHALL be 3 clk cycles; 5 cycles when the filter of REQ-025 is compiled in.

Reset
REQ-022 While rst_n is asserted low, SHALL force duty_out=0, period_out=0, valid=0, timeout=0, state IDLE, and all synchroniser and counter flops to 0.
REQ-023 Reset asserted mid-measurement SHALL discard the partial period; after release, the next rise only arms (REQ-013).

Configuration
REQ-024 SHALL compile the glitch filter in with macro PWM_MEAS_GLITCH_FILTER_EN.
REQ-025 With PWM_MEAS_GLITCH_FILTER_EN defined, lvl SHALL change only after the synchronised input holds a new value for 3 consecutive cycles; shorter pulses are ignored.
REQ-026 With PWM_MEAS_GLITCH_FILTER_EN undefined, lvl SHALL equal the second synchroniser flop and no filter logic is generated.

Structure
REQ-027 SHALL place the FSM state encoding (IDLE, MEASURE) and the filter length constant 3 in a shared package pwm_pkg.
REQ-028 SHALL implement the synchroniser plus optional filter as sub-module pwm_sync; edge detect, counters and FSM stay in pwm_meas.

Verification
REQ-029 Bench: P=10 and H=3 for 5 periods -> no valid on the first rise, then valid each period with period_out=10 and duty_out=3, timeout=0.
REQ-030 Bench: drive from the PWM generator with duty=64 and bits=7 -> period_out=129, duty_out=64.
REQ-031 Bench: one rise, then pwm_in held high for 300 cycles -> valid with period_out=255, duty_out=255, timeout=1, state IDLE; the next two rises restore normal measurement with timeout=0.
REQ-032 Bench: rst_n pulsed low during the 3rd period of P=10 -> outputs zero; the first post-reset rise gives no valid, and the second gives period_out=10.
REQ-033 Bench: 1-cycle glitch inside the low phase -> filter compiled in: measurements unchanged (P=10, H=3); filter compiled out: valid with a shortened period_out.
REQ-034 Bench: ena dropped for 20 cycles mid-stream -> no valid while low; outputs held; the second rise after ena returns high produces valid.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM measurement block.
package pwm_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  localparam int FILT_LEN = 3;
  localparam int FILT_CW  = $clog2(FILT_LEN);

endpackage

// File: rtl/pwm_sync.sv
// Two-flop synchroniser for the PWM input, with an optional glitch filter
// compiled in by PWM_MEAS_GLITCH_FILTER_EN.
module pwm_sync
  import pwm_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_i,
  output logic lvl_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= pwm_i;
      s2_q <= s1_q;
    end
  end

`ifdef PWM_MEAS_GLITCH_FILTER_EN
  localparam logic [FILT_CW-1:0] CNT_LAST = FILT_CW'(FILT_LEN - 1);

  logic               filt_q;
  logic [FILT_CW-1:0] cnt_q;
  logic               hit;

  // lvl flips during the FILT_LEN-th consecutive cycle of a new value on s2
  assign hit   = (s2_q != filt_q) && (cnt_q == CNT_LAST);
  assign lvl_o = hit ? s2_q : filt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else if (s2_q == filt_q) begin
      cnt_q  <= '0;
    end else if (hit) begin
      filt_q <= s2_q;
      cnt_q  <= '0;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
    end
  end
`else
  assign lvl_o = s2_q;
`endif

endmodule

// File: rtl/pwm_meas.sv
// PWM period / high-time meter. Optional input glitch filter via
// PWM_MEAS_GLITCH_FILTER_EN (see pwm_sync).
module pwm_meas
  import pwm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] duty_out,
  output logic [WIDTH-1:0] period_out,
  output logic             valid,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic             lvl, lvl_q, rise;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] pcnt_q, pcnt_d, hcnt_q, hcnt_d;
  logic [WIDTH-1:0] duty_q, duty_d, per_q, per_d;
  logic             valid_q, valid_d, tmo_q, tmo_d;

  pwm_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .pwm_i (pwm_in),
    .lvl_o (lvl)
  );

  assign rise = lvl & ~lvl_q;

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    hcnt_d  = hcnt_q;
    duty_d  = duty_q;
    per_d   = per_q;
    valid_d = 1'b0;
    tmo_d   = tmo_q;
    if (!ena) begin
      state_d = IDLE;
      pcnt_d  = '0;
      hcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          pcnt_d = '0;
          hcnt_d = '0;
          // first rise only arms; no measurement yet
          if (rise) begin
            state_d = MEASURE;
            pcnt_d  = WIDTH'(1);
            hcnt_d  = WIDTH'(1);
          end
        end
        MEASURE: begin
          if (rise) begin
            per_d   = pcnt_q;
            duty_d  = hcnt_q;
            valid_d = 1'b1;
            tmo_d   = 1'b0;
            pcnt_d  = WIDTH'(1);
            hcnt_d  = WIDTH'(1);
          end else if (pcnt_q == MAX) begin
            per_d   = MAX;
            duty_d  = lvl ? MAX : '0;
            valid_d = 1'b1;
            tmo_d   = 1'b1;
            state_d = IDLE;
            pcnt_d  = '0;
            hcnt_d  = '0;
          end else begin
            pcnt_d = pcnt_q + 1'b1;
            if (lvl) hcnt_d = hcnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q   <= 1'b0;
      state_q <= IDLE;
      pcnt_q  <= '0;
      hcnt_q  <= '0;
      duty_q  <= '0;
      per_q   <= '0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      lvl_q   <= lvl;
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      hcnt_q  <= hcnt_d;
      duty_q  <= duty_d;
      per_q   <= per_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
    end
  end

  assign duty_out   = duty_q;
  assign period_out = per_q;
  assign valid      = valid_q;
  assign timeout    = tmo_q;

endmodule

// File: tb/tb_pwm_meas.sv
// Directed self-checking bench for pwm_meas (WIDTH=8).
module tb_pwm_meas;
  import pwm_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       pwm_in = 1'b0;
  logic [7:0] duty_out, period_out;
  logic       valid, timeout;

  int         errors = 0;
  int         checks = 0;
  int         vcnt = 0;
  logic [7:0] last_per = '0, last_duty = '0;
  logic       last_tmo = 1'b0;

  pwm_meas #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .pwm_in     (pwm_in),
    .duty_out   (duty_out),
    .period_out (period_out),
    .valid      (valid),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  // record every valid pulse
  always @(negedge clk) begin
    if (valid) begin
      vcnt      <= vcnt + 1;
      last_per  <= period_out;
      last_duty <= duty_out;
      last_tmo  <= timeout;
    end
  end

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pwm_in = v;
    end
  endtask

  task automatic drive_period(input int p, input int h);
    drive(1'b1, h);
    drive(1'b0, p - h);
    #2;
  endtask

  task automatic apply_reset();
    pwm_in = 1'b0;
    ena    = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 5);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (duty_out !== 8'd0) begin errors++; $display("FAIL rst_duty got %0d want 0", duty_out); end
    checks++; if (period_out !== 8'd0) begin errors++; $display("FAIL rst_per got %0d want 0", period_out); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", valid); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_tmo got %b want 0", timeout); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rst_state got %0d want IDLE", dut.state_q); end
    rst_n = 1'b1;
  endtask

  task automatic test_square();
    int base;
    apply_reset();
    base = vcnt;
    drive_period(10, 3);
    checks++; if (vcnt - base !== 0) begin errors++; $display("FAIL sq_arm got %0d valids want 0", vcnt - base); end
    for (int k = 2; k <= 5; k++) begin
      drive_period(10, 3);
      checks++; if (vcnt - base !== k - 1) begin errors++; $display("FAIL sq_cnt%0d got %0d want %0d", k, vcnt - base, k - 1); end
      checks++; if (last_per !== 8'd10) begin errors++; $display("FAIL sq_per%0d got %0d want 10", k, last_per); end
      checks++; if (last_duty !== 8'd3) begin errors++; $display("FAIL sq_duty%0d got %0d want 3", k, last_duty); end
      checks++; if (last_tmo !== 1'b0) begin errors++; $display("FAIL sq_tmo%0d got %b want 0", k, last_tmo); end
    end
  endtask

  // counter 0..2^bits inclusive, high while counter < duty
  task automatic test_pwm_gen();
    int base;
    apply_reset();
    base = vcnt;
    for (int p = 0; p < 3; p++)
      for (int c = 0; c <= (1 << 7); c++) begin
        @(negedge clk);
        pwm_in = (c < 64);
      end
    drive(1'b1, 8);
    #2;
    checks++; if (vcnt - base !== 3) begin errors++; $display("FAIL gen_cnt got %0d want 3", vcnt - base); end
    checks++; if (last_per !== 8'd129) begin errors++; $display("FAIL gen_per got %0d want 129", last_per); end
    checks++; if (last_duty !== 8'd64) begin errors++; $display("FAIL gen_duty got %0d want 64", last_duty); end
  endtask

  task automatic test_saturate();
    int base;
    apply_reset();
    base = vcnt;
    drive(1'b1, 300);
    #2;
    checks++; if (vcnt - base !== 1) begin errors++; $display("FAIL sat_cnt got %0d want 1", vcnt - base); end
    checks++; if (last_per !== 8'd255) begin errors++; $display("FAIL sat_per got %0d want 255", last_per); end
    checks++; if (last_duty !== 8'd255) begin errors++; $display("FAIL sat_duty got %0d want 255", last_duty); end
    checks++; if (last_tmo !== 1'b1) begin errors++; $display("FAIL sat_tmo got %b want 1", last_tmo); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL sat_state got %0d want IDLE", dut.state_q); end
    drive(1'b0, 6);
    drive_period(10, 3);
    checks++; if (vcnt - base !== 1) begin errors++; $display("FAIL sat_rearm got %0d want 1", vcnt - base); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL sat_tmo_hold got %b want 1", timeout); end
    drive_period(10, 3);
    checks++; if (vcnt - base !== 2) begin errors++; $display("FAIL sat_rec_cnt got %0d want 2", vcnt - base); end
    checks++; if (last_per !== 8'd10) begin errors++; $display("FAIL sat_rec_per got %0d want 10", last_per); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL sat_rec_tmo got %b want 0", timeout); end
  endtask

  task automatic test_reset_mid();
    int base;
    apply_reset();
    base = vcnt;
    drive_period(10, 3);
    drive_period(10, 3);
    drive(1'b1, 3);
    drive(1'b0, 2);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (period_out !== 8'd0) begin errors++; $display("FAIL mid_per got %0d want 0", period_out); end
    checks++; if (duty_out !== 8'd0) begin errors++; $display("FAIL mid_duty got %0d want 0", duty_out); end
    checks++; if (valid !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL mid_flags got %b%b want 00", valid, timeout); end
    rst_n = 1'b1;
    drive(1'b0, 3);
    #2;
    base = vcnt;
    drive_period(10, 3);
    checks++; if (vcnt - base !== 0) begin errors++; $display("FAIL mid_arm got %0d want 0", vcnt - base); end
    drive_period(10, 3);
    checks++; if (vcnt - base !== 1) begin errors++; $display("FAIL mid_cnt got %0d want 1", vcnt - base); end
    checks++; if (last_per !== 8'd10) begin errors++; $display("FAIL mid_per2 got %0d want 10", last_per); end
  endtask

  task automatic glitch_period();
    drive(1'b1, 3);
    drive(1'b0, 3);
    drive(1'b1, 1);
    drive(1'b0, 3);
    #2;
  endtask

  task automatic test_glitch();
    int base;
    apply_reset();
    base = vcnt;
    drive_period(10, 3);
    drive_period(10, 3);
    glitch_period();
`ifdef PWM_MEAS_GLITCH_FILTER_EN
    checks++; if (vcnt - base !== 2) begin errors++; $display("FAIL gl_cnt got %0d want 2", vcnt - base); end
    checks++; if (last_per !== 8'd10) begin errors++; $display("FAIL gl_per got %0d want 10", last_per); end
    drive_period(10, 3);
    checks++; if (last_per !== 8'd10 || last_duty !== 8'd3) begin errors++; $display("FAIL gl_next got %0d/%0d want 10/3", last_per, last_duty); end
`else
    checks++; if (vcnt - base !== 3) begin errors++; $display("FAIL gl_cnt got %0d want 3", vcnt - base); end
    checks++; if (last_per !== 8'd6) begin errors++; $display("FAIL gl_per got %0d want 6", last_per); end
    drive_period(10, 3);
    checks++; if (last_per !== 8'd4 || last_duty !== 8'd1) begin errors++; $display("FAIL gl_next got %0d/%0d want 4/1", last_per, last_duty); end
`endif
    drive_period(10, 3);
    checks++; if (last_per !== 8'd10 || last_duty !== 8'd3) begin errors++; $display("FAIL gl_rec got %0d/%0d want 10/3", last_per, last_duty); end
  endtask

  task automatic test_ena();
    int base;
    apply_reset();
    drive_period(10, 4);
    drive_period(10, 4);
    base = vcnt;
    @(negedge clk);
    ena = 1'b0;
    drive_period(10, 3);
    drive_period(10, 3);
    checks++; if (vcnt - base !== 0) begin errors++; $display("FAIL ena_quiet got %0d want 0", vcnt - base); end
    checks++; if (period_out !== 8'd10 || duty_out !== 8'd4) begin errors++; $display("FAIL ena_hold got %0d/%0d want 10/4", period_out, duty_out); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL ena_state got %0d want IDLE", dut.state_q); end
    ena = 1'b1;
    drive_period(10, 3);
    checks++; if (vcnt - base !== 0) begin errors++; $display("FAIL ena_arm got %0d want 0", vcnt - base); end
    drive_period(10, 3);
    checks++; if (vcnt - base !== 1) begin errors++; $display("FAIL ena_cnt got %0d want 1", vcnt - base); end
    checks++; if (last_per !== 8'd10 || last_duty !== 8'd3) begin errors++; $display("FAIL ena_meas got %0d/%0d want 10/3", last_per, last_duty); end
  endtask

  initial begin
    test_reset();
    test_square();
    test_pwm_gen();
    test_saturate();
    test_reset_mid();
    test_glitch();
    test_ena();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
